// File: rtl/fft8_out_reorder.sv
// fft8_out_reorder: output reorder buffer for the 8-point FFT processor.
// Butterfly result pairs arrive in bit-reversed bin order, four pairs per frame.
// Each frame is stored in one half of a ping-pong buffer. It is then streamed out
// in natural bin order 0..7, one bin per cycle, under a valid/ready handshake.
// Optional build macro FFT8_SCALE_EN: adds one register stage on the write side.
// That stage scales every value by 1/8 with round-half-up and saturation.
// Without the macro, data passes through bit-exact.
module fft8_out_reorder #(
    parameter int W     = 16,
    parameter int NBANK = 2
) (
    input  logic                c,
    input  logic                rst,
    input  logic                en,
    output logic                in_ready,
    input  logic signed [W-1:0] X1r,
    input  logic signed [W-1:0] X1i,
    input  logic signed [W-1:0] X2r,
    input  logic signed [W-1:0] X2i,
    output logic signed [W-1:0] yr,
    output logic signed [W-1:0] yi,
    output logic        [2:0]   y_idx,
    output logic                y_valid,
    input  logic                y_ready,
    output logic                y_last
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND
    } state_t;

    // frame buffers, one 8-bin frame per bank
    logic signed [W-1:0] r_mem_r [NBANK][8];
    logic signed [W-1:0] r_mem_i [NBANK][8];

    // write side control
    logic [1:0]       r_wk;
    logic             r_wbank;
    logic [NBANK-1:0] r_full;

    // read side control and registered outputs
    state_t              r_state;
    logic                r_rbank;
    logic signed [W-1:0] r_yr;
    logic signed [W-1:0] r_yi;
    logic [2:0]          r_y_idx;
    logic                r_y_valid;

    // effective write port (directly from inputs, or from the scaling stage)
    logic                w_accept;
    logic                w_we;
    logic                w_wbank;
    logic [1:0]          w_wk;
    logic signed [W-1:0] w_x1r;
    logic signed [W-1:0] w_x1i;
    logic signed [W-1:0] w_x2r;
    logic signed [W-1:0] w_x2i;
    logic [2:0]          w_a1;
    logic [2:0]          w_a2;
    logic                w_set_full;
    logic                w_rd_done;
    logic [2:0]          w_rd_addr;
    logic signed [W-1:0] w_rd_r;
    logic signed [W-1:0] w_rd_i;

    // a pair is taken only while the current write bank has room
    assign in_ready = ~r_full[r_wbank];
    assign w_accept = en && in_ready;

`ifdef FFT8_SCALE_EN
    logic                r_we_p0;
    logic                r_wbank_p0;
    logic [1:0]          r_wk_p0;
    logic signed [W-1:0] r_x1r_p0;
    logic signed [W-1:0] r_x1i_p0;
    logic signed [W-1:0] r_x2r_p0;
    logic signed [W-1:0] r_x2i_p0;

    // clamp a W+1 bit value into W bits
    function automatic logic signed [W-1:0] f_sat(input logic signed [W:0] v);
        if (v[W] != v[W-1])
            f_sat = v[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        else
            f_sat = v[W-1:0];
    endfunction

    // divide by 8: add half an LSB of the result, then arithmetic shift
    function automatic logic signed [W-1:0] f_scale(input logic signed [W-1:0] x);
        logic signed [W:0] t;
        t = {x[W-1], x} + (W+1)'(4);
        t = t >>> 3;
        return f_sat(t);
    endfunction

    // stage p0: control of the pending scaled write
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_we_p0    <= 1'b0;
            r_wbank_p0 <= 1'b0;
            r_wk_p0    <= 2'd0;
        end else begin
            r_we_p0    <= w_accept;
            r_wbank_p0 <= r_wbank;
            r_wk_p0    <= r_wk;
        end
    end

    // stage p0: scaled data of the pending write
    always_ff @(posedge c) begin
        r_x1r_p0 <= f_scale(X1r);
        r_x1i_p0 <= f_scale(X1i);
        r_x2r_p0 <= f_scale(X2r);
        r_x2i_p0 <= f_scale(X2i);
    end

    assign w_we    = r_we_p0;
    assign w_wbank = r_wbank_p0;
    assign w_wk    = r_wk_p0;
    assign w_x1r   = r_x1r_p0;
    assign w_x1i   = r_x1i_p0;
    assign w_x2r   = r_x2r_p0;
    assign w_x2i   = r_x2i_p0;
`else
    assign w_we    = w_accept;
    assign w_wbank = r_wbank;
    assign w_wk    = r_wk;
    assign w_x1r   = X1r;
    assign w_x1i   = X1i;
    assign w_x2r   = X2r;
    assign w_x2i   = X2i;
`endif

    // pair k carries bins bitrev(k) and bitrev(k)+4
    assign w_a1       = {1'b0, w_wk[0], w_wk[1]};
    assign w_a2       = {1'b1, w_wk[0], w_wk[1]};
    assign w_set_full = w_we && (w_wk == 2'd3);
    assign w_rd_done  = (r_state == S_SEND) && y_ready && (r_y_idx == 3'd7);

    // store both results of the pair at their natural-order addresses
    always_ff @(posedge c) begin
        if (w_we) begin
            r_mem_r[w_wbank][w_a1] <= w_x1r;
            r_mem_i[w_wbank][w_a1] <= w_x1i;
            r_mem_r[w_wbank][w_a2] <= w_x2r;
            r_mem_i[w_wbank][w_a2] <= w_x2i;
        end
    end

    // pair counter and write bank; the bank flips once the fourth pair is taken
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_wk    <= 2'd0;
            r_wbank <= 1'b0;
        end else if (w_accept) begin
            r_wk <= r_wk + 2'd1;
            if (r_wk == 2'd3)
                r_wbank <= ~r_wbank;
        end
    end

    // bank occupancy: set by the last write of a frame, cleared when bin 7 is taken.
    // Set and clear never target the same bank because a full bank is never written.
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_full <= '0;
        end else begin
            if (w_set_full && (w_wbank == 1'b0))
                r_full[0] <= 1'b1;
            else if (w_rd_done && (r_rbank == 1'b0))
                r_full[0] <= 1'b0;
            if (w_set_full && (w_wbank == 1'b1))
                r_full[1] <= 1'b1;
            else if (w_rd_done && (r_rbank == 1'b1))
                r_full[1] <= 1'b0;
        end
    end

    // read address: bin 0 when loading a frame, otherwise the bin after the one shown
    assign w_rd_addr = (r_state == S_LOAD) ? 3'd0 : (r_y_idx + 3'd1);
    assign w_rd_r    = r_mem_r[r_rbank][w_rd_addr];
    assign w_rd_i    = r_mem_i[r_rbank][w_rd_addr];

    // read FSM: wait for a full bank, load bin 0, then stream bins under handshake
    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_rbank   <= 1'b0;
            r_yr      <= '0;
            r_yi      <= '0;
            r_y_idx   <= 3'd0;
            r_y_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_full[r_rbank])
                        r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_yr      <= w_rd_r;
                    r_yi      <= w_rd_i;
                    r_y_idx   <= 3'd0;
                    r_y_valid <= 1'b1;
                    r_state   <= S_SEND;
                end
                S_SEND: begin
                    if (y_ready) begin
                        if (r_y_idx == 3'd7) begin
                            r_y_valid <= 1'b0;
                            r_rbank   <= ~r_rbank;
                            r_state   <= r_full[~r_rbank] ? S_LOAD : S_IDLE;
                        end else begin
                            r_y_idx <= r_y_idx + 3'd1;
                            r_yr    <= w_rd_r;
                            r_yi    <= w_rd_i;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign yr      = r_yr;
    assign yi      = r_yi;
    assign y_idx   = r_y_idx;
    assign y_valid = r_y_valid;
    assign y_last  = r_y_valid && (r_y_idx == 3'd7);

endmodule

// File: tb/tb_fft8_out_reorder.sv
// Testbench for fft8_out_reorder: directed frames with hand-computed natural-order results.
// Honours FFT8_SCALE_EN for expected latency and scaled values.
`timescale 1ns/1ps
module tb_fft8_out_reorder;

    localparam int W = 16;
`ifdef FFT8_SCALE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct {
        int x1r;
        int x1i;
        int x2r;
        int x2i;
    } pair_t;

    typedef struct {
        int r;
        int i;
    } bin_t;

    logic                c = 1'b0;
    logic                rst;
    logic                en;
    logic                in_ready;
    logic signed [W-1:0] X1r, X1i, X2r, X2i;
    logic signed [W-1:0] yr, yi;
    logic [2:0]          y_idx;
    logic                y_valid;
    logic                y_ready;
    logic                y_last;

    int checks = 0;
    int errors = 0;

    pair_t pairs [12];
    bin_t  exps  [16];
    pair_t pp    [12];
    int    kmap  [4];

    fft8_out_reorder #(.W(W), .NBANK(2)) dut (
        .c        (c),
        .rst      (rst),
        .en       (en),
        .in_ready (in_ready),
        .X1r      (X1r),
        .X1i      (X1i),
        .X2r      (X2r),
        .X2i      (X2i),
        .yr       (yr),
        .yi       (yi),
        .y_idx    (y_idx),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .y_last   (y_last)
    );

    always #5 c = ~c;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // expected output value for a stored input value
    function automatic int ev(input int x);
`ifdef FFT8_SCALE_EN
        return (x + 4) >>> 3;
`else
        return x;
`endif
    endfunction

    task automatic set_pair(input pair_t p);
        X1r = 16'(p.x1r);
        X1i = 16'(p.x1i);
        X2r = 16'(p.x2r);
        X2i = 16'(p.x2i);
    endtask

    task automatic set_junk();
        X1r = 16'sh5A5A;
        X1i = 16'sh3C3C;
        X2r = -16'sd999;
        X2i = 16'sh0F0F;
    endtask

    // present one pair for one edge, then idle with junk data for gap cycles
    task automatic drive_pair(input pair_t p, input int gap);
        set_pair(p);
        en = 1'b1;
        @(posedge c); #1;
        en = 1'b0;
        for (int g = 0; g < gap; g++) begin
            set_junk();
            @(posedge c); #1;
        end
    endtask

    task automatic send_frame(input int base, input int gap);
        for (int k = 0; k < 4; k++)
            drive_pair(pairs[base + k], (k < 3) ? gap : 0);
    endtask

    // wait (bounded) for a valid bin, compare it, then pass one edge
    task automatic expect_bin(input string tag, input int idx, input int er, input int ei);
        int n;
        n = 0;
        while (!y_valid && n < 60) begin
            @(posedge c); #1;
            n++;
        end
        chk({tag, "_valid"}, y_valid, 1);
        chk({tag, "_idx"}, y_idx, idx);
        chk({tag, "_yr"}, yr, er);
        chk({tag, "_yi"}, yi, ei);
        chk({tag, "_last"}, y_last, (idx == 7) ? 1 : 0);
        @(posedge c); #1;
    endtask

    // send a frame, check exact latency, then every bin cycle by cycle with y_ready=1
    task automatic send_and_check(input string tag, input int base, input int ebase, input int gap);
        y_ready = 1'b1;
        send_frame(base, gap);
        for (int i = 0; i < LAT; i++) begin
            chk({tag, "_lat_low"}, y_valid, 0);
            @(posedge c); #1;
        end
        for (int b = 0; b < 8; b++) begin
            chk({tag, "_valid"}, y_valid, 1);
            chk({tag, "_idx"}, y_idx, b);
            chk({tag, "_yr"}, yr, ev(exps[ebase + b].r));
            chk({tag, "_yi"}, yi, ev(exps[ebase + b].i));
            chk({tag, "_last"}, y_last, (b == 7) ? 1 : 0);
            @(posedge c); #1;
        end
        chk({tag, "_done_low"}, y_valid, 0);
    endtask

    initial begin
        // frame A: bins 0..7 real, 100..107 imaginary
        pairs[0] = '{0, 100, 4, 104};
        pairs[1] = '{2, 102, 6, 106};
        pairs[2] = '{1, 101, 5, 105};
        pairs[3] = '{3, 103, 7, 107};
        for (int b = 0; b < 8; b++) exps[b] = '{b, 100 + b};
        // frame B: extremes and sign changes
        pairs[4] = '{-32768, 7, 32767, -7};
        pairs[5] = '{-1, 8, 1, -8};
        pairs[6] = '{12345, 9, -12345, -9};
        pairs[7] = '{0, 10, -2, -10};
        exps[8]  = '{-32768, 7};
        exps[9]  = '{12345, 9};
        exps[10] = '{-1, 8};
        exps[11] = '{0, 10};
        exps[12] = '{32767, -7};
        exps[13] = '{-12345, -9};
        exps[14] = '{1, -8};
        exps[15] = '{-2, -10};
        // scaling frame: 100 at bin 0, -13 at bin 4, rest zero
        pairs[8]  = '{100, 0, -13, 0};
        pairs[9]  = '{0, 0, 0, 0};
        pairs[10] = '{0, 0, 0, 0};
        pairs[11] = '{0, 0, 0, 0};
        // bit-reversed bin carried by X1 of pair k
        kmap[0] = 0; kmap[1] = 2; kmap[2] = 1; kmap[3] = 3;
        for (int p = 0; p < 12; p++) begin
            int v;
            v = 16 * (p / 4) + kmap[p % 4];
            pp[p] = '{v, -v - 1, v + 4, -(v + 4) - 1};
        end

        rst = 1'b1;
        en = 1'b0;
        y_ready = 1'b1;
        X1r = '0; X1i = '0; X2r = '0; X2i = '0;
        repeat (2) @(posedge c);
        #1;
        chk("rst_valid", y_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_yr", yr, 0);
        chk("rst_yi", yi, 0);
        chk("rst_idx", y_idx, 0);
        chk("rst_last", y_last, 0);
        rst = 1'b0;
        @(posedge c); #1;

        // reorder: table of frames, back-to-back pairs
        for (int f = 0; f < 2; f++)
            send_and_check((f == 0) ? "frameA" : "frameB", 4 * f, 8 * f, 0);

        // backpressure at bin 3 for 5 cycles
        y_ready = 1'b1;
        send_frame(0, 0);
        for (int b = 0; b < 3; b++) expect_bin("bp_pre", b, ev(b), ev(100 + b));
        y_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_valid", y_valid, 1);
            chk("bp_hold_idx", y_idx, 3);
            chk("bp_hold_yr", yr, ev(3));
            chk("bp_hold_yi", yi, ev(103));
            @(posedge c); #1;
        end
        y_ready = 1'b1;
        for (int b = 3; b < 8; b++) expect_bin("bp_post", b, ev(b), ev(100 + b));
        chk("bp_done_low", y_valid, 0);

        // ping-pong full: 8 pairs fill both banks while the output is stalled
        y_ready = 1'b0;
        for (int p = 0; p < 8; p++) begin
            chk("pp_ready_open", in_ready, 1);
            drive_pair(pp[p], 0);
        end
        chk("pp_ready_shut", in_ready, 0);
        set_junk();
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge c); #1;
            chk("pp_ready_held", in_ready, 0);
        end
        chk("pp_stall_valid", y_valid, 1);
        chk("pp_stall_idx", y_idx, 0);
        chk("pp_stall_yi", yi, ev(-1));
        fork
            begin
                for (int p = 8; p < 12; p++) begin
                    logic acc;
                    int   n;
                    set_pair(pp[p]);
                    en = 1'b1;
                    acc = 1'b0;
                    n = 0;
                    while (!acc && n < 200) begin
                        @(negedge c);
                        acc = in_ready;
                        @(posedge c); #1;
                        n++;
                    end
                    chk("pp_accept", acc, 1);
                end
                en = 1'b0;
            end
            begin
                y_ready = 1'b1;
                for (int f = 0; f < 3; f++)
                    for (int b = 0; b < 8; b++)
                        expect_bin("pp_bin", b, ev(16 * f + b), ev(-(16 * f + b) - 1));
            end
        join
        chk("pp_done_low", y_valid, 0);
        chk("pp_ready_end", in_ready, 1);

        // gapped input: en 1,0,0,1,0,0,...
        send_and_check("gap", 0, 0, 2);

        // asynchronous reset mid-stream with one unread frame and a partial frame
        y_ready = 1'b0;
        send_frame(4, 0);
        repeat (LAT) begin
            @(posedge c); #1;
        end
        chk("mr_pre_valid", y_valid, 1);
        chk("mr_pre_yr", yr, ev(-32768));
        drive_pair(pairs[0], 0);
        drive_pair(pairs[1], 0);
        #3;
        rst = 1'b1;
        #1;
        chk("mr_valid", y_valid, 0);
        chk("mr_in_ready", in_ready, 1);
        chk("mr_yr", yr, 0);
        chk("mr_yi", yi, 0);
        chk("mr_idx", y_idx, 0);
        chk("mr_last", y_last, 0);
        @(posedge c); #1;
        rst = 1'b0;
        send_and_check("after_rst", 0, 0, 0);

`ifdef FFT8_SCALE_EN
        // scaling: 100 -> 13, -13 -> -2, three cycles of latency
        y_ready = 1'b1;
        send_frame(8, 0);
        for (int i = 0; i < 3; i++) begin
            chk("sc_lat_low", y_valid, 0);
            @(posedge c); #1;
        end
        expect_bin("sc_b0", 0, 13, 0);
        for (int b = 1; b < 4; b++) expect_bin("sc_bz", b, 0, 0);
        expect_bin("sc_b4", 4, -2, 0);
        for (int b = 5; b < 8; b++) expect_bin("sc_bz", b, 0, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
